// File: rtl/hc595_serial_rx_if.sv
// rtl/hc595_serial_rx_if.sv - serial stream inputs and parallel word outputs of the 595-style receiver
interface hc595_serial_rx_if #(
    parameter int WIDTH = 16,
    parameter int CNT_W = 8
);
    localparam int BCW = $clog2(WIDTH + 2);

    logic             serial_in;
    logic             shift_en;
    logic             latch_in;
    logic [WIDTH-1:0] par_out;
    logic             par_valid;
    logic             frame_err;
    logic [BCW-1:0]   bit_cnt;
    logic [CNT_W-1:0] frame_cnt;

    // Driver side: produces the serial stream and observes the deserialized word
    modport master (
        output serial_in, shift_en, latch_in,
        input  par_out, par_valid, frame_err, bit_cnt, frame_cnt
    );

    // Receiver side: consumes the serial stream and presents the deserialized word
    modport slave (
        input  serial_in, shift_en, latch_in,
        output par_out, par_valid, frame_err, bit_cnt, frame_cnt
    );
endinterface

// File: rtl/hc595_serial_rx.sv
// rtl/hc595_serial_rx.sv - 74HC595-chain deserializer with frame length check and good-frame counter
module hc595_serial_rx #(
    parameter int WIDTH     = 16,
    parameter int MSB_FIRST = 1,
    parameter int CNT_W     = 8
) (
    input  logic              s_clk,
    input  logic              s_reset,
    hc595_serial_rx_if.slave  bus
);
    localparam int BCW = $clog2(WIDTH + 2);
    localparam logic [BCW-1:0] CNT_FULL = BCW'(WIDTH);
    localparam logic [BCW-1:0] CNT_OVR  = BCW'(WIDTH + 1);

    logic [WIDTH-1:0] sr_q,        sr_d;
    logic [BCW-1:0]   bit_cnt_q,   bit_cnt_d;
    logic [WIDTH-1:0] par_out_q,   par_out_d;
    logic             par_valid_q, par_valid_d;
    logic             frame_err_q, frame_err_d;
    logic [CNT_W-1:0] frame_cnt_q, frame_cnt_d;
    logic [BCW-1:0]   cnt_base;

    // Next-state: shift register, bit counter and storage register with frame check
    always_comb begin
        sr_d        = sr_q;
        bit_cnt_d   = bit_cnt_q;
        par_out_d   = par_out_q;
        par_valid_d = 1'b0;
        frame_err_d = 1'b0;
        frame_cnt_d = frame_cnt_q;

        // A latch starts a new frame; a shift in the same cycle becomes its first bit
        cnt_base = bus.latch_in ? '0 : bit_cnt_q;

        if (bus.shift_en) begin
            if (MSB_FIRST != 0) begin
                sr_d = {sr_q[WIDTH-2:0], bus.serial_in};
            end else begin
                sr_d = {bus.serial_in, sr_q[WIDTH-1:1]};
            end
            // Saturate one past WIDTH so an overrun stays visible until the latch
            bit_cnt_d = (cnt_base == CNT_OVR) ? CNT_OVR : cnt_base + 1'b1;
        end else begin
            bit_cnt_d = cnt_base;
        end

        // Storage register takes the pre-shift contents, as the real 595 does
        if (bus.latch_in) begin
            par_out_d   = sr_q;
            par_valid_d = 1'b1;
            frame_err_d = (bit_cnt_q != CNT_FULL);
            if (bit_cnt_q == CNT_FULL) begin
                frame_cnt_d = frame_cnt_q + 1'b1;
            end
        end
    end

    // State registers with synchronous reset that discards any frame in progress
    always_ff @(posedge s_clk) begin
        if (s_reset) begin
            sr_q        <= '0;
            bit_cnt_q   <= '0;
            par_out_q   <= '0;
            par_valid_q <= 1'b0;
            frame_err_q <= 1'b0;
            frame_cnt_q <= '0;
        end else begin
            sr_q        <= sr_d;
            bit_cnt_q   <= bit_cnt_d;
            par_out_q   <= par_out_d;
            par_valid_q <= par_valid_d;
            frame_err_q <= frame_err_d;
            frame_cnt_q <= frame_cnt_d;
        end
    end

    assign bus.par_out   = par_out_q;
    assign bus.par_valid = par_valid_q;
    assign bus.frame_err = frame_err_q;
    assign bus.bit_cnt   = bit_cnt_q;
    assign bus.frame_cnt = frame_cnt_q;
endmodule

// File: tb/tb_hc595_serial_rx.sv
// tb/tb_hc595_serial_rx.sv - directed bench for MSB-first and LSB-first receiver builds
module tb_hc595_serial_rx;
    logic s_clk;
    logic s_reset;
    int   checks;
    int   errors;

    hc595_serial_rx_if #(.WIDTH(16), .CNT_W(8)) bus_a ();
    hc595_serial_rx_if #(.WIDTH(16), .CNT_W(8)) bus_b ();

    hc595_serial_rx #(.WIDTH(16), .MSB_FIRST(1), .CNT_W(8)) dut_a (
        .s_clk   (s_clk),
        .s_reset (s_reset),
        .bus     (bus_a.slave)
    );

    hc595_serial_rx #(.WIDTH(16), .MSB_FIRST(0), .CNT_W(8)) dut_b (
        .s_clk   (s_clk),
        .s_reset (s_reset),
        .bus     (bus_b.slave)
    );

    initial s_clk = 1'b0;
    always #5 s_clk = ~s_clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input logic rst, input logic sin, input logic sh, input logic la);
        s_reset         = rst;
        bus_a.serial_in = sin;
        bus_a.shift_en  = sh;
        bus_a.latch_in  = la;
        bus_b.serial_in = sin;
        bus_b.shift_en  = sh;
        bus_b.latch_in  = la;
        @(posedge s_clk);
        #1;
    endtask

    task automatic shift_msb(input logic [31:0] w, input int n);
        for (int i = n - 1; i >= 0; i--) step(1'b0, w[i], 1'b1, 1'b0);
    endtask

    task automatic shift_lsb(input logic [31:0] w, input int n);
        for (int i = 0; i < n; i++) step(1'b0, w[i], 1'b1, 1'b0);
    endtask

    initial begin
        logic [31:0] w;
        checks = 0;
        errors = 0;

        // Reset
        step(1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b0);
        chk("rst_par_out",   64'(bus_a.par_out),   64'h0);
        chk("rst_par_valid", 64'(bus_a.par_valid), 64'h0);
        chk("rst_frame_err", 64'(bus_a.frame_err), 64'h0);
        chk("rst_bit_cnt",   64'(bus_a.bit_cnt),   64'h0);
        chk("rst_frame_cnt", 64'(bus_a.frame_cnt), 64'h0);

        // Single clean frame 16'h1234, latch without shift
        shift_msb(32'h1234, 16);
        chk("f1_bit_cnt_pre", 64'(bus_a.bit_cnt),   64'd16);
        chk("f1_valid_pre",   64'(bus_a.par_valid), 64'h0);
        step(1'b0, 1'b0, 1'b0, 1'b1);
        chk("f1_par_out",   64'(bus_a.par_out),   64'h1234);
        chk("f1_par_valid", 64'(bus_a.par_valid), 64'h1);
        chk("f1_frame_err", 64'(bus_a.frame_err), 64'h0);
        chk("f1_frame_cnt", 64'(bus_a.frame_cnt), 64'd1);
        chk("f1_bit_cnt",   64'(bus_a.bit_cnt),   64'd0);
        step(1'b0, 1'b0, 1'b0, 1'b0);
        chk("f1_valid_drop", 64'(bus_a.par_valid), 64'h0);
        chk("f1_par_hold",   64'(bus_a.par_out),   64'h1234);

        // Back-to-back: 1234 then 5678, latch coincides with first bit of 5678
        shift_msb(32'h1234, 16);
        w = 32'h5678;
        step(1'b0, w[15], 1'b1, 1'b1);
        chk("b2b_par_out1",   64'(bus_a.par_out),   64'h1234);
        chk("b2b_valid1",     64'(bus_a.par_valid), 64'h1);
        chk("b2b_err1",       64'(bus_a.frame_err), 64'h0);
        chk("b2b_frame_cnt1", 64'(bus_a.frame_cnt), 64'd2);
        chk("b2b_bit_cnt1",   64'(bus_a.bit_cnt),   64'd1);
        shift_msb(32'h5678, 15);
        step(1'b0, 1'b0, 1'b0, 1'b1);
        chk("b2b_par_out2",   64'(bus_a.par_out),   64'h5678);
        chk("b2b_err2",       64'(bus_a.frame_err), 64'h0);
        chk("b2b_frame_cnt2", 64'(bus_a.frame_cnt), 64'd3);

        // Underrun: 12 bits of ABC on top of sr=5678 leaves stale nibble 8 on top
        shift_msb(32'hABC, 12);
        chk("ur_bit_cnt_pre", 64'(bus_a.bit_cnt), 64'd12);
        step(1'b0, 1'b0, 1'b0, 1'b1);
        chk("ur_par_out",   64'(bus_a.par_out),   64'h8ABC);
        chk("ur_frame_err", 64'(bus_a.frame_err), 64'h1);
        chk("ur_valid",     64'(bus_a.par_valid), 64'h1);
        chk("ur_frame_cnt", 64'(bus_a.frame_cnt), 64'd3);
        step(1'b0, 1'b0, 1'b0, 1'b0);
        chk("ur_err_drop", 64'(bus_a.frame_err), 64'h0);

        // Overrun: 20 bits F1234 keeps the last 16, counter saturates at 17
        shift_msb(32'hF1234, 20);
        chk("or_bit_cnt_pre", 64'(bus_a.bit_cnt), 64'd17);
        step(1'b0, 1'b0, 1'b0, 1'b1);
        chk("or_par_out",   64'(bus_a.par_out),   64'h1234);
        chk("or_frame_err", 64'(bus_a.frame_err), 64'h1);
        chk("or_frame_cnt", 64'(bus_a.frame_cnt), 64'd3);

        // Reset mid-frame overrides a simultaneous latch
        shift_msb(32'hFF, 8);
        step(1'b1, 1'b1, 1'b1, 1'b1);
        chk("mr_par_out",   64'(bus_a.par_out),   64'h0);
        chk("mr_par_valid", 64'(bus_a.par_valid), 64'h0);
        chk("mr_frame_err", 64'(bus_a.frame_err), 64'h0);
        chk("mr_bit_cnt",   64'(bus_a.bit_cnt),   64'h0);
        chk("mr_frame_cnt", 64'(bus_a.frame_cnt), 64'h0);
        step(1'b0, 1'b0, 1'b0, 1'b0);
        chk("mr_no_valid", 64'(bus_a.par_valid), 64'h0);
        shift_msb(32'h5678, 16);
        step(1'b0, 1'b0, 1'b0, 1'b1);
        chk("mr_par_out2",   64'(bus_a.par_out),   64'h5678);
        chk("mr_err2",       64'(bus_a.frame_err), 64'h0);
        chk("mr_frame_cnt2", 64'(bus_a.frame_cnt), 64'd1);

        // LSB-first build with latch held high for two cycles
        step(1'b1, 1'b0, 1'b0, 1'b0);
        shift_lsb(32'h1234, 16);
        chk("lsb_bit_cnt_pre", 64'(bus_b.bit_cnt), 64'd16);
        step(1'b0, 1'b0, 1'b0, 1'b1);
        chk("lsb_par_out1",   64'(bus_b.par_out),   64'h1234);
        chk("lsb_valid1",     64'(bus_b.par_valid), 64'h1);
        chk("lsb_err1",       64'(bus_b.frame_err), 64'h0);
        chk("lsb_frame_cnt1", 64'(bus_b.frame_cnt), 64'd1);
        step(1'b0, 1'b0, 1'b0, 1'b1);
        chk("lsb_par_out2",   64'(bus_b.par_out),   64'h1234);
        chk("lsb_valid2",     64'(bus_b.par_valid), 64'h1);
        chk("lsb_err2",       64'(bus_b.frame_err), 64'h1);
        chk("lsb_frame_cnt2", 64'(bus_b.frame_cnt), 64'd1);
        step(1'b0, 1'b0, 1'b0, 1'b0);
        chk("lsb_valid_drop", 64'(bus_b.par_valid), 64'h0);
        chk("lsb_err_drop",   64'(bus_b.frame_err), 64'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
